fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

- Instruction-fetch front end of the RV32I core; it consumes the branch decision the EX stage produces.
- Holds the program counter and issues word fetches to instruction memory over a valid/ready handshake.
- Applies taken branches and jumps (`branch_signal` + `branch_target`) and drops fetches that are already in flight.
- Pulses `flush` so IF/ID and ID/EX squash wrong-path instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset (must be word-aligned)
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hazard unit: hold IF output and PC
- `branch_signal`  in  1  EX stage: taken branch/JAL/JALR this cycle
- `branch_target`  in  32  EX stage: redirect address, valid when `branch_signal`=1
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  fetch address, stable while `imem_req`=1 and `imem_ready`=0
- `imem_ready`  in  1  memory accepts request and returns data this cycle
- `pc_if`  out  32  PC of instruction handed to IF/ID
- `pc_valid`  out  1  `pc_if` and memory data are a real instruction (0 = bubble)
- `flush`  out  1  one-cycle squash pulse to IF/ID and ID/EX
- `misalign_err`  out  1  sticky: a redirect target had bits [1:0] ≠ 0

## Operation
- States: BOOT, FETCH, DRAIN, HALT.
- Reset values:
  - state=BOOT, pc=`RESET_PC`, redirect_reg=0
  - `imem_req`=0, `pc_valid`=0, `pc_if`=0, `flush`=0, `misalign_err`=0
- BOOT: always go to FETCH next cycle; no request is issued.
- FETCH: `imem_req`=1, `imem_addr`=pc. Priority, highest first:
  1. `branch_signal`=1, target misaligned: `misalign_err`<=1, `flush`<=1, `pc_valid`<=0, go to HALT.
  2. `branch_signal`=1, `imem_ready`=1: discard returned data, pc<=target, `pc_valid`<=0, `flush`<=1, stay in FETCH.
  3. `branch_signal`=1, `imem_ready`=0: redirect_reg<=target, `flush`<=1, `pc_valid`<=0, go to DRAIN.
  4. `imem_ready`=1, `stall`=0: `pc_if`<=pc, `pc_valid`<=1, pc<=pc+4.
  5. `imem_ready`=1, `stall`=1: pc, `pc_if` and `pc_valid` hold; the fetch is repeated next cycle.
  6. `imem_ready`=0, `stall`=0: `pc_valid`<=0 (bubble), pc holds.
  7. `imem_ready`=0, `stall`=1: `pc_if` and `pc_valid` hold, pc holds.
- DRAIN: `imem_req`=1 and `imem_addr`=old pc, because a request that is not yet accepted must not change.
  - `pc_valid`=0 throughout DRAIN.
  - New `branch_signal`: redirect_reg<=new target (last one wins); misaligned target → HALT.
  - `imem_ready`=1: discard the data, pc<=redirect_reg (or the same-cycle new target if `branch_signal`=1), go to FETCH.
- HALT: `imem_req`=0, `pc_valid`=0; only `rst` leaves HALT.
- `flush` is a registered one-cycle pulse. It is 0 in every cycle that does not follow an accepted `branch_signal`.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- `branch_signal` takes precedence over `stall`; a redirect is never lost to a stall.
- `rst` asserted in any state, including mid-DRAIN, returns to reset values next edge; the outstanding request is abandoned.

## Timing
- Reset deasserted at edge E0:
  - BOOT is the state in cycle 1.
  - `imem_req`=1 with `imem_addr`=`RESET_PC` in cycle 2.
  - First `pc_valid`=1 is seen the cycle after the first handshake.
- Fetch latency: handshake in cycle N → `pc_if`/`pc_valid` valid in N+1.
- Throughput: one instruction per cycle with `imem_ready` held at 1.
- Redirect penalty (`imem_ready`=1): `branch_signal` in cycle N → `flush`=1 and `imem_addr`=target in N+1 → first target instruction is `pc_valid` in N+2.
- DRAIN adds one cycle per `imem_ready`=0 cycle.
- All outputs are registered or decoded from state/pc only; there is no combinational path from inputs to outputs.

## Structure
- Shared core defines file, alongside the existing branch-type codes:
  - state encodings (`FETCH_BOOT`, `FETCH_RUN`, `FETCH_DRAIN`, `FETCH_HALT`, 2 bits)
  - default reset vector
- No sub-module: a single state machine plus PC/redirect registers; the +4 adder is inline.

## Test plan
- Reset with `RESET_PC`=32'h0000_1000, `imem_ready`=1 held → addresses 1000, 1004, 1008 issued on consecutive cycles; `pc_valid` first goes high 3 cycles after reset release; `flush` stays 0.
- Taken branch to 32'h0000_0200 while `imem_ready`=1 → next cycle `flush`=1, `pc_valid`=0, `imem_addr`=200; cycle after, `pc_if`=200 with `pc_valid`=1.
- `imem_ready`=0 for 3 cycles, branch to 32'h40 in the first of them, second branch to 32'h80 in the third → `imem_addr` holds the old pc throughout; after `imem_ready` goes 1, `imem_addr`=80; `pc_valid` never high for the old address.
- `stall`=1 for 2 cycles with `imem_ready`=1 → `pc_if` and `imem_addr` unchanged; `branch_signal` during the stall still redirects.
- pc=32'hFFFF_FFF8, `imem_ready`=1 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Branch target 32'h0000_0102 → `misalign_err`=1 and `imem_req`=0 from the next cycle. `rst` pulse in DRAIN or HALT → all outputs at reset values after one edge.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared core defines for the RV32I front end.
// Contents:
//   branch_type_e   - branch comparison codes (funct3 of the B-type opcodes)
//   fetch_state_e   - fetch PC unit state encodings (2 bits)
//   DEFAULT_RESET_PC, PC_STEP - reset vector and sequential fetch increment
//   pc_misaligned() - true when an address is not word-aligned
package fetch_pc_unit_pkg;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } branch_type_e;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2,
    FETCH_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  function automatic logic pc_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC unit of the RV32I core.
// Holds the PC, issues word fetches over a valid/ready handshake, applies EX-stage redirects
// and pulses flush to squash wrong-path instructions.
// Ports:
//   clk, rst       - clock; synchronous active-high reset
//   stall          - hazard unit: hold IF output and PC
//   branch_signal  - EX stage taken branch/jump this cycle
//   branch_target  - redirect address (valid with branch_signal)
//   imem_req/addr  - fetch request valid / word address (decoded from state and pc only)
//   imem_ready     - memory accepts the request and returns data this cycle
//   pc_if/pc_valid - PC handed to IF/ID and its valid flag (0 = bubble)
//   flush          - one-cycle squash pulse following an accepted redirect
//   misalign_err   - sticky: a redirect target was not word-aligned
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_signal,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic [31:0] pc_if,
  output logic        pc_valid,
  output logic        flush,
  output logic        misalign_err
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_redirect;
  logic [31:0]  r_pc_if;
  logic         r_pc_valid;
  logic         r_flush;
  logic         r_misalign;

  logic         w_tgt_bad;
  logic [31:0]  w_pc_next_seq;
  logic [31:0]  w_drain_target;

  assign w_tgt_bad      = pc_misaligned(branch_target);
  assign w_pc_next_seq  = r_pc + PC_STEP;  // wraps modulo 2^32
  // A redirect arriving in the same cycle the drained request completes wins.
  assign w_drain_target = branch_signal ? branch_target : r_redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH_BOOT;
      r_pc       <= RESET_PC;
      r_redirect <= '0;
      r_pc_if    <= '0;
      r_pc_valid <= 1'b0;
      r_flush    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        FETCH_BOOT: begin
          r_state <= FETCH_RUN;
        end

        FETCH_RUN: begin
          if (branch_signal) begin
            // Redirect beats stall; any data returned this cycle is wrong-path.
            r_flush    <= 1'b1;
            r_pc_valid <= 1'b0;
            if (w_tgt_bad) begin
              r_misalign <= 1'b1;
              r_state    <= FETCH_HALT;
            end else if (imem_ready) begin
              r_pc <= branch_target;
            end else begin
              // Request still outstanding: address must stay put until accepted.
              r_redirect <= branch_target;
              r_state    <= FETCH_DRAIN;
            end
          end else if (imem_ready) begin
            if (!stall) begin
              r_pc_if    <= r_pc;
              r_pc_valid <= 1'b1;
              r_pc       <= w_pc_next_seq;
            end
          end else if (!stall) begin
            r_pc_valid <= 1'b0;
          end
        end

        FETCH_DRAIN: begin
          if (branch_signal) begin
            r_flush <= 1'b1;
            if (w_tgt_bad) begin
              r_misalign <= 1'b1;
              r_state    <= FETCH_HALT;
            end else begin
              r_redirect <= branch_target;
            end
          end
          if (imem_ready && !(branch_signal && w_tgt_bad)) begin
            r_pc    <= w_drain_target;
            r_state <= FETCH_RUN;
          end
        end

        FETCH_HALT: begin
          r_pc_valid <= 1'b0;
        end

        default: begin
          r_state <= FETCH_HALT;
        end
      endcase
    end
  end

  assign imem_req     = (r_state == FETCH_RUN) || (r_state == FETCH_DRAIN);
  assign imem_addr    = r_pc;
  assign pc_if        = r_pc_if;
  assign pc_valid     = r_pc_valid;
  assign flush        = r_flush;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios followed by randomized traffic, all checked
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_signal;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] pc_if;
  logic        pc_valid;
  logic        flush;
  logic        misalign_err;

  fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_signal(branch_signal),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .pc_if        (pc_if),
    .pc_valid     (pc_valid),
    .flush        (flush),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_cyc = 0;

  // Model state: which phase the unit is in, plus the architectural values.
  bit          m_boot, m_halt, m_drain;
  logic [31:0] m_pc, m_redir, m_pc_if;
  bit          m_pv, m_flush, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, n_cyc, obs, exp);
    end
  endtask

  task automatic model_step(input logic b, input logic [31:0] t, input logic rdy,
                            input logic stl, input logic rs);
    if (rs) begin
      m_boot = 1; m_halt = 0; m_drain = 0;
      m_pc = RST_PC; m_redir = 0; m_pc_if = 0;
      m_pv = 0; m_flush = 0; m_err = 0;
      return;
    end
    m_flush = 0;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      m_pv = 0;
    end else if (b && (t % 4) != 0) begin
      m_err = 1; m_flush = 1; m_pv = 0; m_halt = 1; m_drain = 0;
    end else if (m_drain) begin
      if (b) begin
        m_redir = t;
        m_flush = 1;
      end
      if (rdy) begin
        m_pc = m_redir;
        m_drain = 0;
      end
    end else if (b) begin
      m_flush = 1;
      m_pv = 0;
      if (rdy) m_pc = t;
      else begin
        m_redir = t;
        m_drain = 1;
      end
    end else if (rdy) begin
      if (!stl) begin
        m_pc_if = m_pc;
        m_pv = 1;
        m_pc = m_pc + 4;
      end
    end else if (!stl) begin
      m_pv = 0;
    end
  endtask

  task automatic check_model();
    logic req_exp;
    req_exp = !m_boot && !m_halt;
    chk("imem_req", {31'd0, imem_req}, {31'd0, req_exp});
    if (req_exp) chk("imem_addr", imem_addr, m_pc);
    chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_pv});
    chk("pc_if", pc_if, m_pc_if);
    chk("flush", {31'd0, flush}, {31'd0, m_flush});
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
  endtask

  task automatic step(input logic b, input logic [31:0] t, input logic rdy,
                      input logic stl, input logic rs);
    branch_signal = b;
    branch_target = t;
    imem_ready    = rdy;
    stall         = stl;
    rst           = rs;
    @(posedge clk);
    n_cyc++;
    model_step(b, t, rdy, stl, rs);
    #1;
    check_model();
  endtask

  logic        rb, rr, rs_q, rrst;
  logic [31:0] rt;
  int          halt_cnt;

  initial begin
    rst = 1'b1; stall = 1'b0; branch_signal = 1'b0; branch_target = '0; imem_ready = 1'b0;

    // Reset and streaming from RESET_PC.
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc_if", pc_if, 32'd0);
    step(0, 0, 1, 0, 0);                    // BOOT -> FETCH
    chk("boot_addr", imem_addr, 32'h1000);
    step(0, 0, 1, 0, 0);
    chk("seq_addr1", imem_addr, 32'h1004);
    chk("first_valid_pc", pc_if, 32'h1000);
    step(0, 0, 1, 0, 0);
    chk("seq_addr2", imem_addr, 32'h1008);

    // Taken branch with memory ready.
    step(1, 32'h200, 1, 0, 0);
    chk("br_flush", {31'd0, flush}, 32'd1);
    chk("br_addr", imem_addr, 32'h200);
    step(0, 0, 1, 0, 0);
    chk("br_pc_if", pc_if, 32'h200);
    step(0, 0, 1, 0, 0);

    // Drain: two redirects while the request is outstanding, last one wins.
    step(1, 32'h40, 0, 0, 0);
    chk("drain_addr_hold", imem_addr, 32'h208);
    step(0, 0, 0, 0, 0);
    step(1, 32'h80, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("drain_target", imem_addr, 32'h80);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // Stall holds, a redirect during stall is still taken.
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("stall_addr", imem_addr, 32'h88);
    step(1, 32'h300, 1, 1, 0);
    chk("stall_br_addr", imem_addr, 32'h300);
    step(0, 0, 1, 0, 0);

    // PC wrap-around.
    step(1, 32'hFFFF_FFF8, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("wrap_fffc", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 1, 0, 0);
    chk("wrap_zero", imem_addr, 32'h0000_0000);
    step(0, 0, 1, 0, 0);

    // Misaligned target halts; reset recovers.
    step(1, 32'h102, 1, 0, 0);
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    step(0, 0, 1, 0, 0);
    step(1, 32'h400, 1, 0, 0);              // ignored in HALT
    step(0, 0, 1, 0, 1);
    chk("halt_rst_err", {31'd0, misalign_err}, 32'd0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // Reset mid-drain.
    step(1, 32'h500, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("drain_rst_req", {31'd0, imem_req}, 32'd0);
    step(0, 0, 1, 0, 0);

    // Randomized traffic.
    halt_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      rb   = ($urandom_range(0, 6) == 0);
      rt   = $urandom;
      if ($urandom_range(0, 9) == 0) rt = 32'hFFFF_FFF0 | (rt & 32'hF);
      if ($urandom_range(0, 24) != 0) rt[1:0] = 2'b00;
      rr   = ($urandom_range(0, 9) < 7);
      rs_q = ($urandom_range(0, 4) == 0);
      halt_cnt = m_halt ? halt_cnt + 1 : 0;
      rrst = (halt_cnt > 3) || ($urandom_range(0, 149) == 0);
      step(rb, rt, rr, rs_q, rrst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
